// File: rtl/hdlc_tx_sequencer_if.sv
// Transmit-side bus of the HDLC sequencer: control strobes, the Tx buffer port and line/status outputs.
interface hdlc_tx_sequencer_if;
    logic       Tx_Start;
    logic       Tx_AbortFrame;
    logic [7:0] Tx_FrameSize;
    logic       Tx_RdBuff;
    logic [7:0] Tx_DataOutBuff;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_AbortedTrans;
    logic       Tx_Done;

    modport master (
        output Tx_Start, Tx_AbortFrame, Tx_FrameSize, Tx_DataOutBuff,
        input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
    );

    modport slave (
        input  Tx_Start, Tx_AbortFrame, Tx_FrameSize, Tx_DataOutBuff,
        output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
    );
endinterface

// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit framer: flag, zero-stuffed payload and FCS-16, flag, one bit per cycle LSB first.
// Every output is a flop loaded from the next-state logic, so Tx/strobes line up with the state.
module hdlc_tx_sequencer #(
    parameter int MAX_BYTES = 126,
    parameter bit FCS_EN    = 1'b1
) (
    input logic           Clk,
    input logic           Rst,
    hdlc_tx_sequencer_if.slave txIf
);
    typedef enum logic [2:0] {IDLE, SFLAG, DATA, FCS, EFLAG, ABORT} state_t;

    localparam logic [7:0] FLAG   = 8'h7E;
    localparam logic [7:0] MAX_SZ = 8'(MAX_BYTES);

    state_t      state, nState;
    logic [3:0]  bitCnt, nBitCnt;
    logic [7:0]  byteIdx, nByteIdx;
    logic [2:0]  onesCnt, nOnes;
    logic [7:0]  frameSize, nFrameSize;
    logic [15:0] crc, nCrc;
    logic        txReg, nTx;
    logic        validReg, nValid;
    logic        rdReg, nRd;
    logic        doneReg, nDone;
    logic        abortedReg, nAborted;
    logic [7:0]  holdReg;
    logic        rdPend;
    logic [7:0]  byteNow;
    logic [3:0]  nxtCnt;
    logic        lastByte;

    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    endfunction

    // A freshly fetched byte is on the bus during the cycle it must start shifting out.
    assign byteNow  = rdPend ? txIf.Tx_DataOutBuff : holdReg;
    assign nxtCnt   = bitCnt + 4'd1;
    assign lastByte = (byteIdx == frameSize - 8'd1);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            bitCnt     <= '0;
            byteIdx    <= '0;
            onesCnt    <= '0;
            frameSize  <= '0;
            crc        <= 16'hFFFF;
            txReg      <= 1'b1;
            validReg   <= 1'b0;
            rdReg      <= 1'b0;
            doneReg    <= 1'b0;
            abortedReg <= 1'b0;
            holdReg    <= '0;
            rdPend     <= 1'b0;
        end else begin
            state      <= nState;
            bitCnt     <= nBitCnt;
            byteIdx    <= nByteIdx;
            onesCnt    <= nOnes;
            frameSize  <= nFrameSize;
            crc        <= nCrc;
            txReg      <= nTx;
            validReg   <= nValid;
            rdReg      <= nRd;
            doneReg    <= nDone;
            abortedReg <= nAborted;
            rdPend     <= rdReg;
            if (rdPend) holdReg <= txIf.Tx_DataOutBuff;
        end
    end

    always_comb begin
        nState     = state;
        nBitCnt    = bitCnt;
        nByteIdx   = byteIdx;
        nOnes      = onesCnt;
        nFrameSize = frameSize;
        nCrc       = crc;
        nTx        = txReg;
        nRd        = 1'b0;
        nDone      = 1'b0;
        nAborted   = abortedReg;

        case (state)
            IDLE: begin
                nTx = 1'b1;
                if (txIf.Tx_Start && txIf.Tx_FrameSize != 8'd0 && txIf.Tx_FrameSize <= MAX_SZ) begin
                    nState     = SFLAG;
                    nBitCnt    = '0;
                    nByteIdx   = '0;
                    nOnes      = '0;
                    nFrameSize = txIf.Tx_FrameSize;
                    nCrc       = 16'hFFFF;
                    nTx        = FLAG[0];
                    nAborted   = 1'b0;
                end
            end
            SFLAG: begin
                if (bitCnt == 4'd7) begin
                    nState  = DATA;
                    nBitCnt = '0;
                    nTx     = byteNow[0];
                    nCrc    = crcStep(crc, byteNow[0]);
                    nOnes   = byteNow[0] ? 3'd1 : 3'd0;
                end else begin
                    nBitCnt = nxtCnt;
                    nTx     = FLAG[nxtCnt[2:0]];
                    nRd     = (bitCnt == 4'd5);
                end
            end
            DATA, FCS: begin
                if (onesCnt == 3'd5) begin
                    // stuffed zero: counters hold, CRC untouched
                    nTx   = 1'b0;
                    nOnes = '0;
                end else begin
                    if (state == DATA) begin
                        if (bitCnt == 4'd7) begin
                            nBitCnt = '0;
                            if (!lastByte) begin
                                nByteIdx = byteIdx + 8'd1;
                                nTx      = byteNow[0];
                                nCrc     = crcStep(crc, byteNow[0]);
                            end else if (FCS_EN) begin
                                nState = FCS;
                                nTx    = ~crc[0];
                            end else begin
                                nState = EFLAG;
                                nTx    = FLAG[0];
                            end
                        end else begin
                            nBitCnt = nxtCnt;
                            nTx     = holdReg[nxtCnt[2:0]];
                            nCrc    = crcStep(crc, holdReg[nxtCnt[2:0]]);
                            nRd     = (bitCnt == 4'd5) && !lastByte;
                        end
                    end else begin
                        if (bitCnt == 4'd15) begin
                            nState  = EFLAG;
                            nBitCnt = '0;
                            nTx     = FLAG[0];
                        end else begin
                            nBitCnt = nxtCnt;
                            nTx     = ~crc[nxtCnt];
                        end
                    end
                    nOnes = (nState == EFLAG || !nTx) ? 3'd0 : onesCnt + 3'd1;
                end
            end
            EFLAG: begin
                if (bitCnt == 4'd7) begin
                    nState  = IDLE;
                    nBitCnt = '0;
                    nTx     = 1'b1;
                    nDone   = 1'b1;
                end else begin
                    nBitCnt = nxtCnt;
                    nTx     = FLAG[nxtCnt[2:0]];
                end
            end
            ABORT: begin
                nTx = 1'b1;
                if (bitCnt == 4'd7) begin
                    nState  = IDLE;
                    nBitCnt = '0;
                end else begin
                    nBitCnt = nxtCnt;
                end
            end
            default: nState = IDLE;
        endcase

        // The closing flag's last bit wins over a coincident abort.
        if (txIf.Tx_AbortFrame && (state inside {SFLAG, DATA, FCS, EFLAG}) &&
            !(state == EFLAG && bitCnt == 4'd7)) begin
            nState   = ABORT;
            nBitCnt  = '0;
            nOnes    = '0;
            nTx      = 1'b0;
            nRd      = 1'b0;
            nDone    = 1'b0;
            nAborted = 1'b1;
        end

        nValid = nState inside {SFLAG, DATA, FCS, EFLAG};
    end

    assign txIf.Tx              = txReg;
    assign txIf.Tx_ValidFrame   = validReg;
    assign txIf.Tx_RdBuff       = rdReg;
    assign txIf.Tx_Done         = doneReg;
    assign txIf.Tx_AbortedTrans = abortedReg;
endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Bench for hdlc_tx_sequencer: directed and random frames against a bit-stream model of the HDLC line.
module tb_hdlc_tx_sequencer;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    hdlc_tx_sequencer_if bus ();
    hdlc_tx_sequencer #(.MAX_BYTES(126), .FCS_EN(1'b1)) dut (.Clk(Clk), .Rst(Rst), .txIf(bus));

    int         nChecks = 0;
    int         nPass   = 0;
    logic [7:0] mem [0:255];
    int         rdIdx   = 0;
    bit         rdPrev  = 0;
    bit         expBits[$];
    bit         expRdQ[$];
    int         byteStart[$];
    int         fcsStart;
    bit         capTx[$];
    logic [7:0] decBytes[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        assert (obs === expv) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Buffer model: answers a read strobe with the next byte one cycle later, garbage otherwise.
    task automatic tick();
        @(negedge Clk);
        if (rdPrev) begin
            bus.Tx_DataOutBuff = mem[rdIdx];
            rdIdx++;
        end else begin
            bus.Tx_DataOutBuff = 8'($urandom);
        end
        rdPrev = bus.Tx_RdBuff;
    endtask

    function automatic logic [15:0] fcsOf(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {8'h00, mem[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected line content of a whole frame plus where each read strobe belongs.
    task automatic buildModel(input int n);
        logic [7:0]  v;
        logic [7:0]  flag;
        logic [15:0] f;
        int          ones;
        flag = 8'h7E;
        f    = fcsOf(n);
        ones = 0;
        expBits.delete(); expRdQ.delete(); byteStart.delete();
        for (int i = 0; i < 8; i++) begin expBits.push_back(flag[i]); expRdQ.push_back(i == 6); end
        for (int b = 0; b < n + 2; b++) begin
            if (b < n) begin v = mem[b]; byteStart.push_back(expBits.size()); end
            else if (b == n) begin v = f[7:0]; fcsStart = expBits.size(); end
            else v = f[15:8];
            for (int i = 0; i < 8; i++) begin
                expBits.push_back(v[i]);
                expRdQ.push_back(i == 6 && b + 1 < n);
                ones = v[i] ? ones + 1 : 0;
                if (ones == 5) begin expBits.push_back(1'b0); expRdQ.push_back(1'b0); ones = 0; end
            end
        end
        for (int i = 0; i < 8; i++) begin expBits.push_back(flag[i]); expRdQ.push_back(1'b0); end
    endtask

    task automatic decode();
        bit   b[$];
        int   ones;
        logic [7:0] v;
        ones = 0;
        decBytes.delete();
        for (int i = 8; i < capTx.size() - 8; i++) begin
            if (ones == 5) begin ones = 0; continue; end
            b.push_back(capTx[i]);
            ones = capTx[i] ? ones + 1 : 0;
        end
        for (int i = 0; i + 8 <= b.size(); i += 8) begin
            for (int j = 0; j < 8; j++) v[j] = b[i + j];
            decBytes.push_back(v);
        end
    endtask

    task automatic sendFrame(input int n, input int abortAt, input int rstAt, input int restartAt,
                             input string tag);
        int len, last, rdCnt, doneCnt, expRd, cut;
        bit effAbort, eTx, eVal, eRd, eDone, eAb;
        buildModel(n);
        len      = expBits.size();
        effAbort = (abortAt >= 0) && (abortAt < len - 1);
        last     = effAbort ? abortAt + 11 : (rstAt >= 0 ? rstAt + 4 : len + 3);
        rdIdx = 0; rdPrev = 0; rdCnt = 0; doneCnt = 0;
        capTx.delete();
        tick();
        bus.Tx_Start = 1'b1; bus.Tx_FrameSize = n[7:0];
        tick();
        bus.Tx_Start = 1'b0; bus.Tx_FrameSize = 8'($urandom);
        for (int k = 0; k <= last; k++) begin
            if (effAbort && k > abortAt) begin
                eTx = (k != abortAt + 1); eVal = 0; eRd = 0; eDone = 0; eAb = 1;
            end else if (rstAt >= 0 && k > rstAt) begin
                eTx = 1; eVal = 0; eRd = 0; eDone = 0; eAb = 0;
            end else if (k < len) begin
                eTx = expBits[k]; eVal = 1; eRd = expRdQ[k]; eDone = 0; eAb = 0;
            end else begin
                eTx = 1; eVal = 0; eRd = 0; eDone = (k == len); eAb = 0;
            end
            chk({tag, ".tx"},      bus.Tx,              eTx);
            chk({tag, ".valid"},   bus.Tx_ValidFrame,   eVal);
            chk({tag, ".rdbuff"},  bus.Tx_RdBuff,       eRd);
            chk({tag, ".done"},    bus.Tx_Done,         eDone);
            chk({tag, ".aborted"}, bus.Tx_AbortedTrans, eAb);
            if (bus.Tx_ValidFrame) capTx.push_back(bus.Tx);
            rdCnt   += int'(bus.Tx_RdBuff);
            doneCnt += int'(bus.Tx_Done);
            bus.Tx_AbortFrame = (k == abortAt);
            Rst               = (k == rstAt);
            bus.Tx_Start      = (k == restartAt);
            if (k == restartAt) bus.Tx_FrameSize = 8'd5;
            tick();
        end
        bus.Tx_AbortFrame = 1'b0; Rst = 1'b0; bus.Tx_Start = 1'b0;
        cut = effAbort ? abortAt : (rstAt >= 0 ? rstAt : len - 1);
        expRd = 0;
        for (int i = 0; i <= cut; i++) expRd += int'(expRdQ[i]);
        chk({tag, ".rdcount"},   rdCnt,   expRd);
        chk({tag, ".donecount"}, doneCnt, (effAbort || rstAt >= 0) ? 0 : 1);
    endtask

    task automatic idleCheck(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            chk({tag, ".tx"},     bus.Tx,            1);
            chk({tag, ".valid"},  bus.Tx_ValidFrame, 0);
            chk({tag, ".rdbuff"}, bus.Tx_RdBuff,     0);
            chk({tag, ".done"},   bus.Tx_Done,       0);
            tick();
        end
    endtask

    task automatic ignoredStart(input logic [7:0] sz, input string tag);
        bus.Tx_Start = 1'b1; bus.Tx_FrameSize = sz;
        tick();
        bus.Tx_Start = 1'b0;
        idleCheck(10, tag);
        chk({tag, ".aborted"}, bus.Tx_AbortedTrans, 0);
    endtask

    logic [8:0]  field;
    logic [15:0] fcs;
    string       s;
    int          n;

    initial begin
        bus.Tx_Start = 1'b0; bus.Tx_AbortFrame = 1'b0;
        bus.Tx_FrameSize = 8'd0; bus.Tx_DataOutBuff = 8'd0;

        // T1: reset and quiet line
        Rst = 1'b1;
        tick(); tick();
        Rst = 1'b0;
        chk("reset.aborted", bus.Tx_AbortedTrans, 0);
        idleCheck(20, "reset");

        // T2: "123456789" carries the X-25 check value
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        sendFrame(9, -1, -1, -1, "crc");
        decode();
        chk("crc.nbytes", decBytes.size(), 11);
        for (int i = 0; i < 9; i++) chk("crc.data", decBytes[i], 8'h31 + 8'(i));
        chk("crc.fcslo", decBytes[9],  8'h6E);
        chk("crc.fcshi", decBytes[10], 8'h90);

        // T3: single 0xFF byte needs one stuffed zero
        mem[0] = 8'hFF;
        sendFrame(1, -1, -1, -1, "stuff");
        for (int i = 0; i < 9; i++) field[i] = capTx[8 + i];
        chk("stuff.field", field, 9'h1DF);
        decode();
        fcs = fcsOf(1);
        chk("stuff.nbytes", decBytes.size(), 3);
        chk("stuff.fcslo", decBytes[1], fcs[7:0]);
        chk("stuff.fcshi", decBytes[2], fcs[15:8]);

        // T4: abort in the middle of byte 3
        for (int i = 0; i < 10; i++) mem[i] = 8'($urandom);
        buildModel(10);
        sendFrame(10, byteStart[3] + 2, -1, -1, "abort");
        idleCheck(4, "postabort");

        // abort coinciding with the last closing-flag bit is ignored
        for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
        buildModel(3);
        sendFrame(3, expBits.size() - 1, -1, -1, "lateabort");

        // T5: out-of-range sizes, and a start request mid-frame
        ignoredStart(8'd0,   "size0");
        ignoredStart(8'd127, "size127");
        ignoredStart(8'($urandom_range(128, 255)), "sizebig");
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        sendFrame(4, -1, -1, 20, "restart");

        // T6: reset while the FCS is going out, then a clean frame
        for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
        buildModel(6);
        sendFrame(6, -1, fcsStart + 3, -1, "rstfcs");
        for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
        sendFrame(6, -1, -1, -1, "afterrst");

        // random frames, biased toward long runs of ones
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) mem[i] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            s = $sformatf("rand%0d", r);
            sendFrame(n, -1, -1, -1, s);
        end

        // largest accepted frame
        for (int i = 0; i < 126; i++) mem[i] = 8'($urandom);
        sendFrame(126, -1, -1, -1, "max");
        decode();
        chk("max.nbytes", decBytes.size(), 128);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
